// File: rtl/control_busqueda_if.sv
// rtl/control_busqueda_if.sv - launch/result handshake between the search controller and the hash core
interface control_busqueda_if #(
  parameter int NONCE_W = 24
);
  logic               core_start;
  logic [NONCE_W-1:0] core_nonce;
  logic               core_done;
  logic [15:0]        hash_hi;

  modport master (
    output core_start,
    output core_nonce,
    input  core_done,
    input  hash_hi
  );

  modport slave (
    input  core_start,
    input  core_nonce,
    output core_done,
    output hash_hi
  );
endinterface

// File: rtl/control_busqueda.sv
// rtl/control_busqueda.sv - walks the entry buffer and drives the hash core nonce by nonce until a bounty is found
module control_busqueda #(
  parameter int NONCE_W = 24,
  parameter int PTR_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               start,
  input  logic [PTR_W-1:0]   num_entradas,
  input  logic [15:0]        target,
  control_busqueda_if.master core,
  output logic [PTR_W-1:0]   rd_ptr,
  output logic [NONCE_W-1:0] bounty_out,
  output logic               bounty_valid,
  output logic               miss,
  output logic               busy,
  output logic               fin,
  output logic               err
);

  localparam logic [NONCE_W-1:0] NONCE_MAX   = '1;
  localparam logic [7:0]         TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CHECK,
    S_NEXT
  } state_t;

  state_t             state_q, state_n;
  logic [NONCE_W-1:0] nonce_q, nonce_n;
  logic [PTR_W-1:0]   num_q, num_n;
  logic [15:0]        target_q, target_n;
  logic [15:0]        hash_q, hash_n;
  logic [7:0]         cnt_q, cnt_n;

  logic               core_start_n;
  logic [NONCE_W-1:0] core_nonce_n;
  logic [PTR_W-1:0]   rd_ptr_n;
  logic [NONCE_W-1:0] bounty_out_n;
  logic               bounty_valid_n;
  logic               miss_n;
  logic               busy_n;
  logic               fin_n;
  logic               err_n;

  // Next-state and next-output decode; pulses default low, everything else holds.
  always_comb begin
    state_n        = state_q;
    nonce_n        = nonce_q;
    num_n          = num_q;
    target_n       = target_q;
    hash_n         = hash_q;
    cnt_n          = cnt_q;
    core_start_n   = 1'b0;
    core_nonce_n   = core.core_nonce;
    rd_ptr_n       = rd_ptr;
    bounty_out_n   = bounty_out;
    bounty_valid_n = 1'b0;
    miss_n         = 1'b0;
    fin_n          = fin;
    err_n          = err;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          fin_n    = 1'b0;
          err_n    = 1'b0;
          rd_ptr_n = '0;
          nonce_n  = '0;
          num_n    = num_entradas;
          target_n = target;
          state_n  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        core_start_n = 1'b1;
        core_nonce_n = nonce_q;
        cnt_n        = 8'd0;
        state_n      = S_WAIT;
      end
      S_WAIT: begin
        if (core.core_done) begin
          hash_n  = core.hash_hi;
          state_n = S_CHECK;
        end else if (cnt_q == TIMEOUT_CNT) begin
          // Hung core: abandon the whole job without publishing a bounty.
          err_n   = 1'b1;
          fin_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      S_CHECK: begin
        if (hash_q < target_q) begin
          bounty_out_n   = nonce_q;
          bounty_valid_n = 1'b1;
          state_n        = S_NEXT;
        end else if (nonce_q == NONCE_MAX) begin
          // All-ones is the terminal nonce; it doubles as the no-solution marker.
          bounty_out_n   = NONCE_MAX;
          bounty_valid_n = 1'b1;
          miss_n         = 1'b1;
          state_n        = S_NEXT;
        end else begin
          nonce_n = nonce_q + NONCE_W'(1);
          state_n = S_LAUNCH;
        end
      end
      S_NEXT: begin
        if (rd_ptr == num_q) begin
          fin_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          rd_ptr_n = rd_ptr + PTR_W'(1);
          nonce_n  = '0;
          state_n  = S_LAUNCH;
        end
      end
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n != S_IDLE);
  end

  // State register and registered outputs; reset returns all of them to zero.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q         <= S_IDLE;
      nonce_q         <= '0;
      num_q           <= '0;
      target_q        <= '0;
      hash_q          <= '0;
      cnt_q           <= '0;
      core.core_start <= 1'b0;
      core.core_nonce <= '0;
      rd_ptr          <= '0;
      bounty_out      <= '0;
      bounty_valid    <= 1'b0;
      miss            <= 1'b0;
      busy            <= 1'b0;
      fin             <= 1'b0;
      err             <= 1'b0;
    end else begin
      state_q         <= state_n;
      nonce_q         <= nonce_n;
      num_q           <= num_n;
      target_q        <= target_n;
      hash_q          <= hash_n;
      cnt_q           <= cnt_n;
      core.core_start <= core_start_n;
      core.core_nonce <= core_nonce_n;
      rd_ptr          <= rd_ptr_n;
      bounty_out      <= bounty_out_n;
      bounty_valid    <= bounty_valid_n;
      miss            <= miss_n;
      busy            <= busy_n;
      fin             <= fin_n;
      err             <= err_n;
    end
  end

endmodule

// File: doc/control_busqueda.md
# control_busqueda

Sequencing controller for the hash search datapath. It walks the input-entry buffer from index 0 up to `num_entradas` via `rd_ptr`. For each entry it launches the hash core on successive 24-bit nonces until a hash meets the difficulty target or the nonce space is exhausted. It publishes each winning nonce (bounty) and raises `fin` when the last entry is resolved; it also aborts on a hung core.

## Interface
Parameters:
- `NONCE_W`, 24, nonce/bounty width
- `PTR_W`, 2, entry-pointer width
- `TIMEOUT`, 255, max cycles in WAIT before abort (counter 8 bits wide)

Ports (clock is `clk`; reset is `reset_L`, asynchronous, active-low):
- `clk`  in  1  clock
- `reset_L`  in  1  asynchronous active-low reset
- `start`  in  1  begin job; sampled only in IDLE
- `num_entradas`  in  PTR_W  highest entry index to process (0..3), latched at start
- `target`  in  16  difficulty; hit when `hash_hi < target`, latched at start
- `core_done`  in  1  one-cycle pulse from hash core, `hash_hi` valid same cycle
- `hash_hi`  in  16  top 16 bits of core result
- `core_start`  out  1  one-cycle launch pulse to hash core
- `core_nonce`  out  NONCE_W  nonce presented to core, stable from core_start until done
- `rd_ptr`  out  PTR_W  entry index presented to input buffer
- `bounty_out`  out  NONCE_W  last resolved nonce (24'hFFFFFF = no solution)
- `bounty_valid`  out  1  one-cycle pulse when `bounty_out` updates
- `miss`  out  1  one-cycle pulse alongside bounty_valid when nonce space exhausted
- `busy`  out  1  high whenever state != IDLE
- `fin`  out  1  job complete; sticky until next accepted start
- `err`  out  1  timeout abort; sticky until next accepted start

## Operation
- All outputs registered. Reset: state IDLE; all outputs 0; nonce, latched num/target and WAIT counter 0.
- IDLE: on `start`, do all of:
  - clear fin and err
  - set rd_ptr=0 and nonce=0
  - latch num_entradas and target
  - go to LAUNCH

  With no start, hold all outputs.
- LAUNCH: core_start<=1 for one cycle, core_nonce<=nonce, clear WAIT counter, go to WAIT.
- WAIT:
  - On core_done, capture hash_hi and go to CHECK.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, set err<=1 and fin<=1 and go to IDLE; no bounty is issued.
- CHECK:
  - Hit (captured hash_hi < latched target): bounty_out<=nonce, bounty_valid<=1, go to NEXT.
  - No hit and nonce==all-ones: bounty_out<=24'hFFFFFF, bounty_valid<=1, miss<=1, go to NEXT.
  - Otherwise: nonce<=nonce+1, go to LAUNCH.
- NEXT:
  - If rd_ptr == latched num: fin<=1, go to IDLE, rd_ptr held.
  - Else: rd_ptr<=rd_ptr+1, nonce<=0, go to LAUNCH.
- Comparison is unsigned 16-bit. target=0 never hits, so every entry ends in miss. Nonce increment never wraps; all-ones is the terminal value.
- core_done outside WAIT is ignored. start while busy is ignored.
- Changing num_entradas/target mid-job has no effect.
- Reset asserted mid-job returns to IDLE immediately with outputs 0. The core is not notified; its late core_done is ignored.

## Timing
- start sampled at edge S → core_start high cycle after S+1 (nonce 0, rd_ptr 0); busy high from S.
- core_done sampled at edge D:
  - Miss → next core_start from edge D+2.
  - Hit → bounty_valid high from D+1 for one cycle.
  - Hit, not last entry → rd_ptr increments at D+2; next core_start at D+3.
  - Hit, last entry → fin high and busy low from D+2.
- Per-nonce overhead: 2 cycles beyond core latency.
- Timeout: if core_start rises at edge L and no done arrives, err and fin rise at edge L+TIMEOUT+1.
- core_nonce/rd_ptr change only at LAUNCH/NEXT edges; they are stable throughout WAIT.

## Test plan
- Reset mid-job: assert reset_L=0 during WAIT → all outputs 0 asynchronously; a subsequent core_done is ignored; a new start runs normally.
- Single entry, early hit: num_entradas=0, target=16'h0100, core returns hash_hi=16'hFFFF for nonces 0..2 and 16'h00FF for nonce 3 (latency 4). Required response:
  - bounty_out=24'h000003, one bounty_valid pulse
  - fin high 1 cycle after the bounty pulse
  - rd_ptr stays 0
- Four entries: num_entradas=3, hits at nonces 5, 0, 9, 1. Required response:
  - bounty_valid pulses carry 5, 0, 9, 1
  - rd_ptr steps 0→1→2→3
  - fin after the fourth pulse
  - a second start re-runs from rd_ptr 0
- Exhaustion: target=0 with nonce preloaded near limit via short-NONCE_W build (NONCE_W=4) → 16 launches, bounty_out=all-ones, miss pulse coincident with bounty_valid, fin.
- Hung core: TIMEOUT=8, core never asserts done → err=1 and fin=1 exactly 9 edges after core_start; busy falls; bounty_valid never pulses.
- Ignored events: start while busy, core_done in IDLE/CHECK, num_entradas changed mid-job → no state or output disturbance; outputs match the unperturbed run.
